fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmitter that drains the read side of the asynchronous FIFO in the UART TX clock domain. Whenever the FIFO reports non-empty, it pops one word and sends it as a UART frame on `tx_out`: start bit, data LSB first, optional parity, stop bit. It runs on the FIFO's read clock and drives the FIFO's `rd_inc` directly. The FIFO must present `rd_data` first-word-fall-through, i.e. valid whenever `empty` = 0.

## Interface
- `DATA_WIDTH`, 8, width of each FIFO word and number of data bits per frame
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; must be ≥ 2
- `clk`  in  1  transmit clock (same clock as the FIFO read side)
- `rst`  in  1  reset; one clock, asynchronous, active-high
- `fifo_rd_data`  in  DATA_WIDTH  FIFO head word; valid while `fifo_empty` = 0
- `fifo_empty`  in  1  FIFO empty flag (read domain)
- `par_en`  in  1  1 = append a parity bit
- `par_typ`  in  1  0 = even parity, 1 = odd parity
- `fifo_rd_inc`  out  1  pop strobe to FIFO `rd_inc`; one cycle per frame
- `tx_out`  out  1  serial line; idles high
- `busy`  out  1  high while a frame is on the line

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Reset:** state = IDLE, `tx_out` = 1, `busy` = 0, `fifo_rd_inc` = 0. All counters and the shift register are 0.
- **IDLE:**
  - `fifo_rd_inc` = (state == IDLE) & !`fifo_empty`. This is combinational and lasts exactly one cycle.
  - On that same edge: capture `fifo_rd_data` into the shift register, latch `par_en`/`par_typ`, compute the parity bit, and go to START.
  - Parity bit = ^data for even parity, ~^data for odd parity.
- **Per-frame config:** the latched `par_en`/`par_typ` hold for the whole frame. Changing the inputs mid-frame has no effect.
- **START:** `tx_out` = 0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:**
  - Send bit index 0..DATA_WIDTH-1, LSB first, each held for CLKS_PER_BIT cycles.
  - After the last bit, go to PARITY if latched `par_en` = 1, otherwise to STOP.
- **PARITY:** `tx_out` = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- **STOP:** `tx_out` = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- **busy:** `busy` = (state != IDLE), registered. It is 0 in the pop cycle.
- **Counters:**
  - Tick counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary.
  - Bit counter: $clog2(DATA_WIDTH) bits, cleared on entry to DATA.
- **Between frames:** IDLE always lasts at least one cycle (`tx_out` = 1). With the FIFO non-empty, back-to-back frames are separated by exactly one extra idle-high cycle.
- **Pop timing:** no second pop can occur before the FIFO's empty flag updates, because the next IDLE is at least 2·CLKS_PER_BIT+1 cycles away.
- **Reset mid-frame:**
  - Asynchronously forces `tx_out` = 1 and `busy` = 0 and aborts the frame.
  - The popped word is lost and is not re-popped.
  - After release, operation resumes from IDLE.
- **fifo_empty asserted mid-frame:** ignored; it is only sampled in IDLE.

## Timing
- `tx_out` and `busy` are registered. `fifo_rd_inc` is combinational from state and `fifo_empty`.
- Pop cycle = C0. `tx_out` falls and `busy` rises at the edge ending C0.
- Frame length: (DATA_WIDTH+2)·CLKS_PER_BIT cycles without parity, (DATA_WIDTH+3)·CLKS_PER_BIT with parity.
- With CLKS_PER_BIT = 4 and 8 data bits:
  - Frame = 40 cycles (no parity) or 44 cycles (parity).
  - Pop-to-pop period with the FIFO never empty = 41 or 45 cycles.
- Latency from `fifo_empty` falling (in IDLE) to the start bit on `tx_out`: 1 cycle.
- All outputs are glitch-free except `fifo_rd_inc`, which is sampled only by the FIFO on `clk`.

## Test plan
Defaults for all cases: CLKS_PER_BIT = 4, DATA_WIDTH = 8.

- **Reset/idle:** assert `rst`, then release with `fifo_empty` = 1 for 20 cycles.
  - Required: `tx_out` = 1, `busy` = 0, `fifo_rd_inc` = 0 throughout.
- **Single byte, no parity:** FIFO holds 0xA5, `par_en` = 0.
  - Exactly one `fifo_rd_inc` pulse.
  - `tx_out` = 0, 1,0,1,0,0,1,0,1, then 1; each level held 4 cycles.
  - `busy` high for 40 cycles, then IDLE with no further pop.
- **Parity:** 0xA5 with `par_en` = 1.
  - `par_typ` = 0: parity bit 0. `par_typ` = 1: parity bit 1.
  - Frame lasts 44 cycles.
  - Toggling `par_en` during the DATA state does not change the current frame.
- **Back-to-back:** FIFO holds 0x11, 0x22, 0x33.
  - Three pops, 41 cycles apart.
  - Exactly one idle-high cycle between frames.
  - Decoded bytes are 0x11, 0x22, 0x33 in order.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0x3C.
  - `tx_out` goes to 1 and `busy` to 0 immediately, without waiting for a clock edge.
  - After release with `fifo_empty` = 1: no pop and the line stays high. With `fifo_empty` = 0: the next word is sent normally.
- **Empty toggling mid-frame:** `fifo_empty` pulses 1→0→1 during a frame.
  - No extra `fifo_rd_inc`.
  - The frame completes unchanged.

Source files
------------

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_tx
//  Purpose  : UART transmitter draining a first-word-fall-through FIFO.
//             Pops one word whenever the FIFO is non-empty in IDLE and sends
//             start bit, data LSB first, optional parity, stop bit.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  fifo_rd_inc,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] c_TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] c_BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [TW-1:0]         r_tick;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_tx;
    logic                  r_busy;

    state_t                w_state_nxt;
    logic [TW-1:0]         w_tick_nxt;
    logic [BW-1:0]         w_bit_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_par_en_nxt;
    logic                  w_par_bit_nxt;
    logic                  w_tx_nxt;
    logic                  w_pop;
    logic                  w_tick_end;

    assign w_tick_end  = (r_tick == c_TICK_LAST);
    assign fifo_rd_inc = w_pop;
    assign tx_out      = r_tx;
    assign busy        = r_busy;

    // Next-state, counter and shift-register logic; tx level follows the next state
    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = r_tick;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_par_en_nxt  = r_par_en;
        w_par_bit_nxt = r_par_bit;
        w_pop         = 1'b0;

        if (r_state == IDLE) begin
            if (!fifo_empty) begin
                // Pop and latch the frame configuration in the same cycle
                w_pop         = 1'b1;
                w_shift_nxt   = fifo_rd_data;
                w_par_en_nxt  = par_en;
                w_par_bit_nxt = par_typ ? ~^fifo_rd_data : ^fifo_rd_data;
                w_tick_nxt    = '0;
                w_state_nxt   = START;
            end
        end else begin
            w_tick_nxt = w_tick_end ? '0 : r_tick + 1'b1;
        end

        case (r_state)
            START: begin
                if (w_tick_end) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_tick_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == c_BIT_LAST) begin
                        w_state_nxt = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_tick_end) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_tick_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: ;
        endcase

        // Line level for the coming cycle, so tx_out can be a plain register
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = w_par_bit_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame and idles the line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tick    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_uart_tx
//  Purpose  : Self-checking bench for fifo_uart_tx. Stimulus pushes words into
//             a FIFO model and expected frames into a scoreboard; a monitor
//             decodes tx_out and compares against the scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         pbit;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] fifo_rd_data;
    logic       fifo_empty;
    logic       par_en;
    logic       par_typ;
    logic       fifo_rd_inc;
    logic       tx_out;
    logic       busy;

    int         checks   = 0;
    int         failures = 0;

    logic [7:0] fq[$];
    exp_t       exp_q[$];
    int         pop_times[$];
    bit         force_ne = 1'b0;
    bit         pop_flag = 1'b0;
    int         cyc      = 0;
    bit         in_frame = 1'b0;

    fifo_uart_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty  (fifo_empty),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .fifo_rd_inc (fifo_rd_inc),
        .tx_out      (tx_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop recorder plus frame decoder, sampled on the falling edge
    initial begin : monitor
        exp_t       cur;
        logic [11:0] ebits;
        logic [7:0] rx;
        int         nb, samp, bad, bi;
        bit         post;
        post = 1'b0; nb = 0; samp = 0; bad = 0; rx = '0; ebits = '1;
        forever begin
            @(negedge clk);
            cyc++;
            pop_flag = (fifo_rd_inc === 1'b1);
            if (pop_flag) pop_times.push_back(cyc);
            if (rst !== 1'b0) begin
                in_frame = 1'b0;
                post     = 1'b0;
            end else begin
                if (post) begin
                    post = 1'b0;
                    check(busy === 1'b0, "idle_gap_busy", int'(busy), 0);
                    check(tx_out === 1'b1, "idle_gap_tx", int'(tx_out), 1);
                end
                if (!in_frame && tx_out === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_frame", 1, 0);
                    end else begin
                        cur   = exp_q.pop_front();
                        ebits = '1;
                        ebits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) ebits[i+1] = cur.data[i];
                        if (cur.pen) ebits[9] = cur.pbit;
                        nb       = cur.pen ? 11 : 10;
                        in_frame = 1'b1;
                        samp     = 0;
                        bad      = 0;
                        rx       = '0;
                    end
                end
                if (in_frame) begin
                    bi = samp / CPB;
                    if (tx_out !== ebits[bi] || busy !== 1'b1) bad++;
                    if (bi >= 1 && bi <= 8 && (samp % CPB) == CPB/2) rx[bi-1] = tx_out;
                    samp++;
                    if (samp == nb * CPB) begin
                        in_frame = 1'b0;
                        post     = 1'b1;
                        check(rx == cur.data, "rx_data", int'(rx), int'(cur.data));
                        check(bad == 0, "frame_shape_bad_samples", bad, 0);
                    end
                end
            end
        end
    end

    task automatic upd();
        fifo_empty   = force_ne ? 1'b0 : (fq.size() == 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_flag && fq.size() != 0) void'(fq.pop_front());
        upd();
    endtask

    task automatic push(input logic [7:0] d, input bit pen, input bit pbit);
        exp_t e;
        e.data = d; e.pen = pen; e.pbit = pbit;
        fq.push_back(d);
        exp_q.push_back(e);
        upd();
    endtask

    task automatic run(input int n, output int bcnt, output int idle_bad);
        bcnt = 0; idle_bad = 0;
        repeat (n) begin
            tick();
            if (busy === 1'b1) bcnt++;
            if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_rd_inc !== 1'b0) idle_bad++;
        end
    endtask

    // Directed stimulus
    initial begin : stim
        int b, b2, b3, ib, n0;
        par_en = 1'b0; par_typ = 1'b0;
        upd();

        // Reset and idle
        #2 rst = 1'b1;
        #1;
        check(tx_out === 1'b1, "reset_tx", int'(tx_out), 1);
        check(busy === 1'b0, "reset_busy", int'(busy), 0);
        check(fifo_rd_inc === 1'b0, "reset_rd_inc", int'(fifo_rd_inc), 0);
        tick(); tick();
        rst = 1'b0;
        n0 = pop_times.size();
        run(20, b, ib);
        check(ib == 0, "idle_20_cycles", ib, 0);
        check(pop_times.size() - n0 == 0, "idle_no_pop", pop_times.size() - n0, 0);

        // Single byte 0xA5, no parity
        n0 = pop_times.size();
        push(8'hA5, 1'b0, 1'b0);
        #1;
        check(fifo_rd_inc === 1'b1, "pop_strobe_comb", int'(fifo_rd_inc), 1);
        tick();
        check(tx_out === 1'b0, "start_latency_tx", int'(tx_out), 0);
        check(busy === 1'b1, "start_latency_busy", int'(busy), 1);
        run(49, b, ib);
        check(b == 39, "a5_busy_len", b + 1, 40);
        check(pop_times.size() - n0 == 1, "a5_pop_count", pop_times.size() - n0, 1);

        // Parity even (0xA5 has four ones -> parity bit 0)
        par_en = 1'b1; par_typ = 1'b0;
        push(8'hA5, 1'b1, 1'b0);
        run(55, b, ib);
        check(b == 44, "even_par_busy_len", b, 44);

        // Parity odd -> parity bit 1
        par_typ = 1'b1;
        push(8'hA5, 1'b1, 1'b1);
        run(55, b, ib);
        check(b == 44, "odd_par_busy_len", b, 44);

        // Config changed mid-frame: latched odd parity frame keeps its shape
        par_en = 1'b1; par_typ = 1'b1;
        push(8'hA5, 1'b1, 1'b1);
        run(10, b, ib);
        par_en = 1'b0; par_typ = 1'b0;
        run(45, b2, ib);
        check(b + b2 == 44, "par_latched_on_len", b + b2, 44);

        // par_en toggled high during DATA of a no-parity frame
        push(8'hA5, 1'b0, 1'b0);
        run(10, b, ib);
        par_en = 1'b1;
        run(10, b2, ib);
        par_en = 1'b0;
        run(30, b3, ib);
        check(b + b2 + b3 == 40, "par_latched_off_len", b + b2 + b3, 40);

        // Back-to-back frames
        n0 = pop_times.size();
        push(8'h11, 1'b0, 1'b0);
        push(8'h22, 1'b0, 1'b0);
        push(8'h33, 1'b0, 1'b0);
        run(140, b, ib);
        check(pop_times.size() - n0 == 3, "b2b_pop_count", pop_times.size() - n0, 3);
        if (pop_times.size() - n0 == 3) begin
            check(pop_times[n0+1] - pop_times[n0] == 41, "b2b_spacing_1",
                  pop_times[n0+1] - pop_times[n0], 41);
            check(pop_times[n0+2] - pop_times[n0+1] == 41, "b2b_spacing_2",
                  pop_times[n0+2] - pop_times[n0+1], 41);
        end
        check(b == 120, "b2b_busy_total", b, 120);

        // Reset during data bit 3 of 0x3C
        push(8'h3C, 1'b0, 1'b0);
        repeat (18) tick();
        #3 rst = 1'b1;
        #1;
        check(tx_out === 1'b1, "async_rst_tx", int'(tx_out), 1);
        check(busy === 1'b0, "async_rst_busy", int'(busy), 0);
        tick(); tick();
        rst = 1'b0;
        n0 = pop_times.size();
        run(20, b, ib);
        check(ib == 0, "post_rst_idle", ib, 0);
        check(pop_times.size() - n0 == 0, "post_rst_no_pop", pop_times.size() - n0, 0);
        push(8'h5A, 1'b0, 1'b0);
        run(50, b, ib);
        check(b == 40, "post_rst_frame_len", b, 40);
        check(pop_times.size() - n0 == 1, "post_rst_pop_count", pop_times.size() - n0, 1);

        // fifo_empty pulses 1->0->1 mid-frame
        n0 = pop_times.size();
        push(8'hC3, 1'b0, 1'b0);
        run(10, b, ib);
        force_ne = 1'b1; upd();
        run(3, b2, ib);
        force_ne = 1'b0; upd();
        run(40, b3, ib);
        check(pop_times.size() - n0 == 1, "empty_glitch_pop_count", pop_times.size() - n0, 1);
        check(b + b2 + b3 == 40, "empty_glitch_frame_len", b + b2 + b3, 40);

        repeat (5) tick();
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        check(in_frame == 1'b0, "monitor_idle_at_end", int'(in_frame), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
